// File: rtl/arm_pkg.sv
// Shared types for the ARM pipeline sequencer: SRAM handshake states,
// forwarding selects, in-flight instruction shadow slot and NZCV bit positions.
package arm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   typedef struct packed {
      logic       valid;
      logic [3:0] dest;
      logic       wb_en;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       s;
      logic [3:0] src1;
      logic [3:0] src2;
      logic       src1_used;
      logic       src2_used;
   } slot_t;

   localparam slot_t NOP_SLOT = '0;

   function automatic logic writes_reg(input slot_t sl, input logic [3:0] r);
      return sl.valid & sl.wb_en & (sl.dest == r);
   endfunction

   function automatic logic is_mem_access(input slot_t sl);
      return sl.valid & (sl.mem_r_en | sl.mem_w_en);
   endfunction

   // MEM wins over WB; a load in MEM has no data yet, so it never forwards.
   function automatic logic [1:0] fwd_select(input slot_t mem_s, input slot_t wb_s,
                                             input logic [3:0] src, input logic used);
      if (used && writes_reg(mem_s, src) && !mem_s.mem_r_en) return FWD_MEM;
      if (used && writes_reg(wb_s, src)) return FWD_WB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and pipeline_ctrl.
// master = the sequencer, slave = the datapath that obeys its controls.
interface pipeline_ctrl_if;

   logic       id_valid;
   logic [3:0] id_src1;
   logic [3:0] id_src2;
   logic       id_src1_used;
   logic       id_src2_used;
   logic [3:0] id_dest;
   logic       id_wb_en;
   logic       id_mem_r_en;
   logic       id_mem_w_en;
   logic       id_s;
   logic       exe_branch_taken;
   logic [3:0] alu_status;
   logic       sram_done;

   logic       sram_start;
   logic       sram_timeout;
   logic       freeze_if;
   logic       freeze_id;
   logic       flush_if;
   logic       bubble_ex;
   logic       freeze_all;
   logic [3:0] status;
   logic [1:0] fwd_sel_a;
   logic [1:0] fwd_sel_b;

   modport master (
      input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dest,
             id_wb_en, id_mem_r_en, id_mem_w_en, id_s, exe_branch_taken,
             alu_status, sram_done,
      output sram_start, sram_timeout, freeze_if, freeze_id, flush_if,
             bubble_ex, freeze_all, status, fwd_sel_a, fwd_sel_b
   );

   modport slave (
      output id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dest,
             id_wb_en, id_mem_r_en, id_mem_w_en, id_s, exe_branch_taken,
             alu_status, sram_done,
      input  sram_start, sram_timeout, freeze_if, freeze_id, flush_if,
             bubble_ex, freeze_all, status, fwd_sel_a, fwd_sel_b
   );

endinterface

// File: rtl/mem_wait_fsm.sv
// SRAM handshake for the MEM stage: start pulse, wait-state freeze and a
// sticky timeout flag once the wait count reaches SRAM_WAIT_MAX.
module mem_wait_fsm
   import arm_pkg::*;
#(
   parameter int SRAM_WAIT_MAX = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_access,
   input  logic sram_done,
   output logic sram_start,
   output logic freeze_all,
   output logic sram_timeout
);

   localparam int CW = $clog2(SRAM_WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(SRAM_WAIT_MAX);

   mem_state_e    state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          timeout_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         sram_timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state        <= state_nxt;
         wait_cnt     <= wait_cnt_nxt;
         sram_timeout <= timeout_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_nxt  = sram_timeout;
      sram_start   = 1'b0;
      freeze_all   = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_access) begin
               sram_start   = 1'b1;
               freeze_all   = 1'b1;
               wait_cnt_nxt = '0;
               state_nxt    = WAIT;
            end
         end
         WAIT: begin
            freeze_all = 1'b1;
            if (sram_done) begin
               wait_cnt_nxt = '0;
               state_nxt    = DONE;
            end else begin
               // Saturate rather than wrap; the flag is sticky until reset.
               if (wait_cnt != CNT_MAX) wait_cnt_nxt = wait_cnt + 1'b1;
               if (wait_cnt_nxt == CNT_MAX) timeout_nxt = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: EX/MEM/WB shadow slots, hazard/branch/freeze control
// and the NZCV register. Define PIPELINE_FORWARD_EN to enable operand forwarding.
module pipeline_ctrl
   import arm_pkg::*;
#(
   parameter int SRAM_WAIT_MAX = 16
) (
   input logic             clk,
   input logic             rst,
   pipeline_ctrl_if.master bus
);

   slot_t      id_slot, ex_slot, mem_slot, wb_slot;
   logic       mem_access, freeze_all, sram_start, sram_timeout;
   logic       stall, branch_flush;
   logic       freeze_if, freeze_id, flush_if, bubble_ex;
   logic [3:0] status_q;
   logic [1:0] fwd_sel_a, fwd_sel_b;

   always_comb begin
      id_slot           = NOP_SLOT;
      id_slot.valid     = bus.id_valid;
      id_slot.dest      = bus.id_dest;
      id_slot.wb_en     = bus.id_wb_en;
      id_slot.mem_r_en  = bus.id_mem_r_en;
      id_slot.mem_w_en  = bus.id_mem_w_en;
      id_slot.s         = bus.id_s;
      id_slot.src1      = bus.id_src1;
      id_slot.src2      = bus.id_src2;
      id_slot.src1_used = bus.id_src1_used;
      id_slot.src2_used = bus.id_src2_used;
   end

   assign mem_access = is_mem_access(mem_slot);

   mem_wait_fsm #(
      .SRAM_WAIT_MAX (SRAM_WAIT_MAX)
   ) u_mem_wait (
      .clk          (clk),
      .rst          (rst),
      .mem_access   (mem_access),
      .sram_done    (bus.sram_done),
      .sram_start   (sram_start),
      .freeze_all   (freeze_all),
      .sram_timeout (sram_timeout)
   );

`ifdef PIPELINE_FORWARD_EN
   // Only a load in EX cannot be forwarded in time: load-use stall.
   assign stall = bus.id_valid & ex_slot.valid & ex_slot.mem_r_en &
                  ((bus.id_src1_used & (ex_slot.dest == bus.id_src1)) |
                   (bus.id_src2_used & (ex_slot.dest == bus.id_src2)));
   assign fwd_sel_a = fwd_select(mem_slot, wb_slot, ex_slot.src1, ex_slot.src1_used);
   assign fwd_sel_b = fwd_select(mem_slot, wb_slot, ex_slot.src2, ex_slot.src2_used);
`else
   // Write-through register file: a WB-slot writer is already visible to ID.
   assign stall = bus.id_valid &
                  ((bus.id_src1_used & (writes_reg(ex_slot, bus.id_src1) |
                                        writes_reg(mem_slot, bus.id_src1))) |
                   (bus.id_src2_used & (writes_reg(ex_slot, bus.id_src2) |
                                        writes_reg(mem_slot, bus.id_src2))));
   assign fwd_sel_a = FWD_REG;
   assign fwd_sel_b = FWD_REG;
`endif

   // Priority: SRAM freeze, then taken branch, then data hazard.
   always_comb begin
      freeze_if    = 1'b0;
      freeze_id    = 1'b0;
      flush_if     = 1'b0;
      bubble_ex    = 1'b0;
      branch_flush = 1'b0;
      if (freeze_all) begin
         freeze_if = 1'b1;
         freeze_id = 1'b1;
      end else if (bus.exe_branch_taken) begin
         flush_if     = 1'b1;
         bubble_ex    = 1'b1;
         branch_flush = 1'b1;
      end else if (stall) begin
         freeze_if = 1'b1;
         freeze_id = 1'b1;
         bubble_ex = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_slot  <= NOP_SLOT;
         mem_slot <= NOP_SLOT;
         wb_slot  <= NOP_SLOT;
      end else if (!freeze_all) begin
         ex_slot  <= bubble_ex ? NOP_SLOT : id_slot;
         mem_slot <= ex_slot;
         wb_slot  <= mem_slot;
      end
   end

   // Flags commit at the end of the S-instruction's EXE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q <= 4'b0000;
      end else if (ex_slot.valid && ex_slot.s && !freeze_all && !branch_flush) begin
         status_q <= bus.alu_status;
      end
   end

   // Not every slot field is consumed in every build.
   logic unused_slot_bits;
   assign unused_slot_bits = ^{ex_slot, mem_slot, wb_slot};

   assign bus.sram_start   = sram_start;
   assign bus.sram_timeout = sram_timeout;
   assign bus.freeze_all   = freeze_all;
   assign bus.freeze_if    = freeze_if;
   assign bus.freeze_id    = freeze_id;
   assign bus.flush_if     = flush_if;
   assign bus.bubble_ex    = bubble_ex;
   assign bus.status       = status_q;
   assign bus.fwd_sel_a    = fwd_sel_a;
   assign bus.fwd_sel_b    = fwd_sel_b;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, RAW stalls, branch flush, SRAM wait,
// timeout and NZCV update. Forwarding vectors apply when PIPELINE_FORWARD_EN is defined.
module tb_pipeline_ctrl;
   import arm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(
      .SRAM_WAIT_MAX (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic [3:0] d,
                         input logic wb, input logic mr, input logic mw, input logic s);
      bus.id_valid     = v;
      bus.id_src1      = s1;
      bus.id_src1_used = u1;
      bus.id_src2      = s2;
      bus.id_src2_used = u2;
      bus.id_dest      = d;
      bus.id_wb_en     = wb;
      bus.id_mem_r_en  = mr;
      bus.id_mem_w_en  = mw;
      bus.id_s         = s;
   endtask

   task automatic drain(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.exe_branch_taken = 1'b0;
      bus.alu_status       = 4'b0000;
      bus.sram_done        = 1'b0;

      // Reset state
      sample();
      check("rst_freeze_all", bus.freeze_all, 0);
      check("rst_sram_start", bus.sram_start, 0);
      check("rst_timeout", bus.sram_timeout, 0);
      check("rst_status", bus.status, 4'b0000);
      check("rst_freeze_if", bus.freeze_if, 0);
      check("rst_bubble_ex", bus.bubble_ex, 0);
      check("rst_flush_if", bus.flush_if, 0);
      check("rst_fwd_a", bus.fwd_sel_a, 0);
      next_cycle();
      rst = 1'b1;

`ifdef PIPELINE_FORWARD_EN
      // MEM ADD R5 forwards to EX SUB reading R5
      set_id(1, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0, 0, 0);
      sample();
      check("fw_add_no_bubble", bus.bubble_ex, 0);
      next_cycle();
      set_id(1, 4'd5, 1, 4'd6, 1, 4'd7, 1, 0, 0, 0);
      sample();
      check("fw_no_stall", bus.freeze_if, 0);
      next_cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      check("fw_sel_a_mem", bus.fwd_sel_a, FWD_MEM);
      check("fw_sel_b_reg", bus.fwd_sel_b, FWD_REG);
      next_cycle();
      // EX LDR R5, ID reads R5: one bubble
      set_id(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0, 0);
      sample();
      check("fw_ldr_no_bubble", bus.bubble_ex, 0);
      next_cycle();
      set_id(1, 4'd5, 1, 4'd6, 0, 4'd8, 1, 0, 0, 0);
      sample();
      check("fw_load_use_bubble", bus.bubble_ex, 1);
      check("fw_load_use_freeze", bus.freeze_if, 1);
      next_cycle();
      sample();
      check("fw_ldr_start", bus.sram_start, 1);
      next_cycle();
      bus.sram_done = 1'b1;
      sample();
      check("fw_ldr_wait", bus.freeze_all, 1);
      next_cycle();
      bus.sram_done = 1'b0;
      sample();
      check("fw_done_no_bubble", bus.bubble_ex, 0);
      check("fw_done_no_freeze", bus.freeze_if, 0);
      next_cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      check("fw_sel_a_wb", bus.fwd_sel_a, FWD_WB);
      drain(3);
`else
      // EX ADD R3, ID reads R3: two bubbles, then released
      set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 0);
      sample();
      check("raw_pre_no_stall", bus.bubble_ex, 0);
      next_cycle();
      set_id(1, 4'd3, 1, 4'd4, 1, 4'd5, 1, 0, 0, 0);
      sample();
      check("raw1_freeze_if", bus.freeze_if, 1);
      check("raw1_freeze_id", bus.freeze_id, 1);
      check("raw1_bubble_ex", bus.bubble_ex, 1);
      next_cycle();
      sample();
      check("raw2_freeze_if", bus.freeze_if, 1);
      check("raw2_bubble_ex", bus.bubble_ex, 1);
      next_cycle();
      sample();
      check("raw3_release_freeze", bus.freeze_if, 0);
      check("raw3_release_bubble", bus.bubble_ex, 0);
      check("raw_fwd_tied", bus.fwd_sel_a, 0);
      drain(3);
`endif

      // Taken branch while ID sits on a RAW hazard: branch wins for one cycle
      set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 0);
      next_cycle();
      set_id(1, 4'd3, 1, 4'd4, 1, 4'd5, 1, 0, 0, 0);
      bus.exe_branch_taken = 1'b1;
      sample();
      check("br_flush_if", bus.flush_if, 1);
      check("br_bubble_ex", bus.bubble_ex, 1);
      check("br_freeze_if", bus.freeze_if, 0);
      check("br_freeze_id", bus.freeze_id, 0);
      next_cycle();
      bus.exe_branch_taken = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      check("br_after_flush", bus.flush_if, 0);
      check("br_after_bubble", bus.bubble_ex, 0);
      drain(3);

      // ADDS with alu_status 0110 commits on the edge ending its EXE cycle
      set_id(1, 4'd8, 1, 4'd9, 1, 4'd7, 1, 0, 0, 1);
      next_cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.alu_status = 4'b0110;
      sample();
      check("st_before_edge", bus.status, 4'b0000);
      next_cycle();
      bus.alu_status = 4'b1111;
      sample();
      check("st_updated", bus.status, 4'b0110);
      next_cycle();
      sample();
      check("st_bubble_holds", bus.status, 4'b0110);

      // LDR in MEM with ADDS in EX; sram_done in the 4th wait cycle
      set_id(1, 4'd1, 1, 4'd0, 0, 4'd4, 1, 1, 0, 0);
      next_cycle();
      set_id(1, 4'd8, 1, 4'd9, 1, 4'd6, 1, 0, 0, 1);
      sample();
      check("ld_adds_no_stall", bus.freeze_if, 0);
      next_cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.alu_status = 4'b1001;
      sample();
      check("ld_start_pulse", bus.sram_start, 1);
      check("ld_start_freeze", bus.freeze_all, 1);
      check("ld_start_freeze_if", bus.freeze_if, 1);
      check("ld_start_no_bubble", bus.bubble_ex, 0);
      check("ld_start_status", bus.status, 4'b0110);
      for (int w = 1; w <= 4; w++) begin
         next_cycle();
         if (w == 4) bus.sram_done = 1'b1;
         sample();
         check($sformatf("ld_wait%0d_freeze", w), bus.freeze_all, 1);
         check($sformatf("ld_wait%0d_start", w), bus.sram_start, 0);
         check($sformatf("ld_wait%0d_status", w), bus.status, 4'b0110);
      end
      next_cycle();
      bus.sram_done = 1'b0;
      sample();
      check("ld_done_freeze", bus.freeze_all, 0);
      check("ld_done_status", bus.status, 4'b0110);
      next_cycle();
      sample();
      check("ld_after_status", bus.status, 4'b1001);
      check("ld_after_idle", bus.freeze_all, 0);
      check("ld_after_timeout_sticky", bus.sram_timeout, 1);
      drain(2);

      // Reset in the middle of a STR wait aborts the access
      set_id(1, 4'd1, 1, 4'd4, 1, 4'd0, 0, 0, 1, 0);
      next_cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      sample();
      check("str_start", bus.sram_start, 1);
      next_cycle();
      sample();
      check("str_wait", bus.freeze_all, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_freeze_all", bus.freeze_all, 0);
      check("mid_rst_start", bus.sram_start, 0);
      check("mid_rst_timeout", bus.sram_timeout, 0);
      check("mid_rst_status", bus.status, 4'b0000);
      check("mid_rst_freeze_if", bus.freeze_if, 0);
      check("mid_rst_bubble", bus.bubble_ex, 0);
      next_cycle();
      rst = 1'b1;
      sample();
      check("post_rst_start0", bus.sram_start, 0);
      check("post_rst_freeze0", bus.freeze_all, 0);
      next_cycle();
      sample();
      check("post_rst_start1", bus.sram_start, 0);

      // No sram_done: timeout after 2 wait cycles, FSM keeps waiting
      set_id(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 1, 0, 0);
      next_cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      sample();
      check("to_start", bus.sram_start, 1);
      next_cycle();
      sample();
      check("to_wait1_clear", bus.sram_timeout, 0);
      next_cycle();
      sample();
      check("to_wait2_clear", bus.sram_timeout, 0);
      next_cycle();
      sample();
      check("to_wait3_set", bus.sram_timeout, 1);
      check("to_wait3_freeze", bus.freeze_all, 1);
      next_cycle();
      next_cycle();
      sample();
      check("to_wait5_sticky", bus.sram_timeout, 1);
      check("to_wait5_freeze", bus.freeze_all, 1);
      check("to_wait5_no_start", bus.sram_start, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage ARM pipeline. It tracks destination/write-back info of in-flight instructions in EXE, MEM and WB; generates stall, freeze and flush controls for the IF/ID and ID/EXE pipeline registers; runs the SRAM wait handshake for the MEM stage; and owns the 4-bit NZCV status register that feeds condition checks and the EXE-stage ALU carry input.

## Interface
Parameters:
- SRAM_WAIT_MAX, 16, wait-cycle bound before `sram_timeout` asserts.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  4  Rn / Rm (or Rd for STR) register numbers.
- id_src1_used, id_src2_used  in  1  operand actually read.
- id_dest  in  4  destination register.
- id_wb_en, id_mem_r_en, id_mem_w_en, id_s  in  1  decoded controls.
- exe_branch_taken  in  1  EXE holds a branch whose condition passed.
- alu_status  in  4  NZCV from the EXE ALU.
- sram_done  in  1  SRAM access complete.
- sram_start  out  1  one-cycle SRAM request pulse.
- sram_timeout  out  1  sticky wait-bound error.
- freeze_if, freeze_id  out  1  hold PC and IF/ID register.
- flush_if  out  1  clear IF/ID register.
- bubble_ex  out  1  load NOP into ID/EXE register.
- freeze_all  out  1  hold every pipeline register (SRAM wait).
- status  out  4  NZCV register, `status[1]` = C drives EXE carry input.
- fwd_sel_a, fwd_sel_b  out  2  EXE operand source (only with FORWARD_EN; otherwise tied 0).

## Operation
- Shadow slots EX, MEM, WB: {valid, dest, wb_en, mem_r_en, mem_w_en, s, src1/src2/used}. They advance with the pipeline when `freeze_all`=0. EX loads NOP when `bubble_ex`=1.
- Register file is write-through. A WB-slot writer never causes a stall.
- Hazard without FORWARD_EN: `stall` = id_valid & a used source equals the dest of a valid wb_en EX or MEM slot.
- Hazard with FORWARD_EN: `stall` only when the EX slot is a load (mem_r_en) whose dest matches a used ID source (load-use).
- `stall` drives freeze_if = freeze_id = bubble_ex = 1.
- Branch: `exe_branch_taken` drives flush_if = bubble_ex = 1, with freeze_if = freeze_id = 0. Branch beats stall.
- SRAM FSM states IDLE, WAIT, DONE:
  - IDLE→WAIT when the MEM slot is a valid access. That cycle: sram_start=1, freeze_all=1.
  - WAIT: freeze_all=1. Go to DONE on sram_done. sram_timeout sets when the wait count reaches SRAM_WAIT_MAX; the FSM keeps waiting.
  - DONE: freeze_all=0, pipeline advances, then IDLE.
- freeze_all has top priority. While it is high: flush_if=0, bubble_ex=0, exe_branch_taken ignored (re-presented later), freeze_if = freeze_id = 1.
- Status: status ← alu_status when the EX slot is valid, s=1, freeze_all=0 and bubble_ex not caused by a branch on the same instruction.

## Timing
- Reset (async, rst=0): all slots invalid, FSM IDLE, status=0000, wait count 0. All outputs 0.
- Reset during WAIT aborts the access. sram_start stays low.
- Hazard, flush and fwd outputs are combinational from slots and ID inputs, same cycle.
- Status updates on the clock edge ending the S-instruction's EXE cycle. Visible to the next ID.
- Memory instruction occupies MEM for a minimum of 3 cycles: start, WAIT with sram_done, DONE.
- RAW distance 1 without forwarding costs 2 bubbles. Distance 2 costs 1.

## Configuration
- `PIPELINE_FORWARD_EN` defined:
  - Stall reduced to load-use.
  - fwd_sel_x = 1 when the MEM slot is valid, wb_en, not a load, and its dest matches the EX source.
  - Otherwise fwd_sel_x = 2 when the WB slot matches.
  - Otherwise 0. MEM beats WB.
- Undefined: full RAW stall, fwd_sel tied 0, and the WB-slot source compare is removed.

## Structure
- Shared package `arm_pkg`: FSM state enum {IDLE, WAIT, DONE}, fwd-select constants FWD_REG=0, FWD_MEM=1, FWD_WB=2, shadow-slot struct typedef, NZCV bit indices.
- One sub-module `mem_wait_fsm`: SRAM handshake, wait counter, timeout. The top level holds slots, hazard logic and status.

## Test plan
- Reset: assert rst=0 mid-WAIT → all outputs 0, status=0000, no sram_start after release.
- No forwarding: EX ADD R3 wb_en, ID reads R3 → freeze_if/freeze_id/bubble_ex high 2 cycles, then released.
- Branch: exe_branch_taken=1 while ID stalled on RAW → flush_if=1, bubble_ex=1, freeze_if=0 for exactly one cycle.
- SRAM: LDR reaches MEM, sram_done after 4 cycles → sram_start one pulse, freeze_all high 5 cycles, then DONE advance. With SRAM_WAIT_MAX=2 and no sram_done → sram_timeout sticks at 1.
- Status: S instruction, alu_status=0110 → status=0110 next edge. Same stimulus during freeze_all → status unchanged until DONE.
- PIPELINE_FORWARD_EN: MEM ADD R5, EX reads R5 → fwd_sel_a=1, no stall. EX LDR R5, ID reads R5 → one bubble.
